encoder_8to3: RTL and testbench



---
 rtl/encoder_8to3.sv | 73 +++++++
 tb/tb_encoder_8to3.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/encoder_8to3.sv
// rtl/encoder_8to3.sv - registered 8-to-3 highest-priority encoder with valid and multi-hot flags
// Optional feature macro: ENC_ONEHOT_CHECK_EN (multi-hot detection plus simulation check).
module encoder_8to3 #(
    parameter int IN_W  = 8,
    parameter int OUT_W = $clog2(IN_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  in,
    output logic [OUT_W-1:0] out,
    output logic             valid,
    output logic             multi_hot
);

    // The encoding table below is only meaningful for an 8-bit input.
    generate
        if (IN_W != 8 || OUT_W != 3) begin : g_bad_width
            $error("encoder_8to3: IN_W must be 8 and OUT_W must be 3");
        end
    endgenerate

    logic [OUT_W-1:0] idx_next;
    logic             valid_next;

    // Ascending scan so the highest set bit is the last one to write idx_next.
    always_comb begin
        idx_next = '0;
        for (int i = 0; i < IN_W; i++) begin
            if (in[i]) begin
                idx_next = OUT_W'(i);
            end
        end
    end

    assign valid_next = |in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out   <= '0;
            valid <= 1'b0;
        end else begin
            out   <= idx_next;
            valid <= valid_next;
        end
    end

`ifdef ENC_ONEHOT_CHECK_EN
    logic multi_next;

    // Clearing the lowest set bit leaves something only when two or more bits were set.
    assign multi_next = |(in & (in - IN_W'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            multi_hot <= 1'b0;
        end else begin
            multi_hot <= multi_next;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(multi_hot && valid))
            else $error("encoder_8to3: multi-hot input encoded, out=%0d", out);
        end
    end
`endif
`else
    assign multi_hot = 1'b0;
`endif

endmodule

// File: tb/tb_encoder_8to3.sv
// tb/tb_encoder_8to3.sv - randomized self-checking bench for encoder_8to3 against a behavioural model
module tb_encoder_8to3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] in_vec = 8'hFF;
    logic [2:0] out;
    logic       valid;
    logic       multi_hot;

    int pass_cnt = 0;
    int total_cnt = 0;

    encoder_8to3 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in_vec),
        .out       (out),
        .valid     (valid),
        .multi_hot (multi_hot)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] model_out(input logic [7:0] v);
        for (int b = 7; b >= 0; b--) begin
            if (v[b]) return 3'(b);
        end
        return 3'd0;
    endfunction

    function automatic logic model_multi(input logic [7:0] v);
`ifdef ENC_ONEHOT_CHECK_EN
        return $countones(v) > 1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic test_reset();
        #3 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (out !== 3'd0) $display("FAIL reset_out got=%0d want=0", out); else pass_cnt++;
        total_cnt++;
        if (valid !== 1'b0) $display("FAIL reset_valid got=%b want=0", valid); else pass_cnt++;
        total_cnt++;
        if (multi_hot !== 1'b0) $display("FAIL reset_multi got=%b want=0", multi_hot); else pass_cnt++;
        @(negedge clk);
        rst_n  = 1'b1;
        in_vec = 8'h00;
        @(negedge clk);
        total_cnt++;
        if (out !== 3'd0) $display("FAIL zero_out got=%0d want=0", out); else pass_cnt++;
        total_cnt++;
        if (valid !== 1'b0) $display("FAIL zero_valid got=%b want=0", valid); else pass_cnt++;
        total_cnt++;
        if (multi_hot !== 1'b0) $display("FAIL zero_multi got=%b want=0", multi_hot); else pass_cnt++;
    endtask

    task automatic test_walk();
        for (int i = 0; i < 8; i++) begin
            in_vec = 8'd1 << i;
            @(negedge clk);
            total_cnt++;
            if (out !== 3'(i)) $display("FAIL walk_out[%0d] got=%0d want=%0d", i, out, i); else pass_cnt++;
            total_cnt++;
            if (valid !== 1'b1) $display("FAIL walk_valid[%0d] got=%b want=1", i, valid); else pass_cnt++;
            total_cnt++;
            if (multi_hot !== 1'b0) $display("FAIL walk_multi[%0d] got=%b want=0", i, multi_hot); else pass_cnt++;
        end
    endtask

    task automatic test_multi_hot();
        logic [7:0] pats [2];
        logic [2:0] want_out [2];
        pats[0] = 8'b1000_0001; want_out[0] = 3'd7;
        pats[1] = 8'b0010_0100; want_out[1] = 3'd5;
        for (int k = 0; k < 2; k++) begin
            in_vec = pats[k];
            @(negedge clk);
            total_cnt++;
            if (out !== want_out[k]) $display("FAIL multi_out[%0d] got=%0d want=%0d", k, out, want_out[k]); else pass_cnt++;
            total_cnt++;
            if (valid !== 1'b1) $display("FAIL multi_valid[%0d] got=%b want=1", k, valid); else pass_cnt++;
            total_cnt++;
            if (multi_hot !== model_multi(pats[k])) $display("FAIL multi_flag[%0d] got=%b want=%b", k, multi_hot, model_multi(pats[k])); else pass_cnt++;
        end
    endtask

    task automatic test_mid_reset();
        in_vec = 8'h40;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (out !== 3'd0) $display("FAIL midrst_out got=%0d want=0", out); else pass_cnt++;
        total_cnt++;
        if (valid !== 1'b0) $display("FAIL midrst_valid got=%b want=0", valid); else pass_cnt++;
        total_cnt++;
        if (multi_hot !== 1'b0) $display("FAIL midrst_multi got=%b want=0", multi_hot); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (out !== 3'd6) $display("FAIL release_out got=%0d want=6", out); else pass_cnt++;
        total_cnt++;
        if (valid !== 1'b1) $display("FAIL release_valid got=%b want=1", valid); else pass_cnt++;
        total_cnt++;
        if (multi_hot !== 1'b0) $display("FAIL release_multi got=%b want=0", multi_hot); else pass_cnt++;
    endtask

    task automatic test_random();
        logic [7:0] v;
        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 3))
                0:       v = 8'd1 << $urandom_range(0, 7);
                1:       v = 8'h00;
                default: v = 8'($urandom_range(0, 255));
            endcase
            in_vec = v;
            @(negedge clk);
            total_cnt++;
            if (out !== model_out(v)) $display("FAIL rand_out in=%h got=%0d want=%0d", v, out, model_out(v)); else pass_cnt++;
            total_cnt++;
            if (valid !== (v != 8'h00)) $display("FAIL rand_valid in=%h got=%b want=%b", v, valid, v != 8'h00); else pass_cnt++;
            total_cnt++;
            if (multi_hot !== model_multi(v)) $display("FAIL rand_multi in=%h got=%b want=%b", v, multi_hot, model_multi(v)); else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_walk();
        test_multi_hot();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
